rr_burst_arbiter: RTL

- Parametrised round-robin arbiter for N requesters sharing one resource; next generation of the team's 2-way registered arbiter.
- Adds a configurable burst limit: a grantee keeps the resource for up to MAX_BURST consecutive cycles while it keeps requesting. After that, priority rotates.
- Grant outputs are registered; sits between requesting masters and a shared bus or memory port.

---
 rtl/rr_burst_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter for N requesters with a per-grant burst limit and registered outputs.
// Optional macro RR_ARB_LOCK_EN adds a per-requester lock input that extends a burst past MAX_BURST.
module rr_burst_arbiter #(
  parameter  int N         = 4,
  parameter  int MAX_BURST = 4,
  localparam int IDW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   request,
`ifdef RR_ARB_LOCK_EN
  input  logic [N-1:0]   lock,
`endif
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid,
  output logic           burst_last
);

  localparam int             CW      = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST - 1);

  logic [N-1:0]   r_grant;
  logic [IDW-1:0] r_grant_id;
  logic           r_grant_valid;
  logic           r_burst_last;
  logic [CW-1:0]  r_cnt;
  logic [IDW-1:0] r_last;

  logic           w_locked;
  logic           w_hold;
  logic           w_found;
  logic [IDW-1:0] w_winner;
  logic [CW-1:0]  w_cnt_inc;

  logic [N-1:0]   w_grant_nxt;
  logic [IDW-1:0] w_grant_id_nxt;
  logic           w_grant_valid_nxt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [IDW-1:0] w_last_nxt;
  logic           w_burst_last_nxt;

`ifdef RR_ARB_LOCK_EN
  assign w_locked = lock[r_grant_id];
`else
  assign w_locked = 1'b0;
`endif

  // A locked grantee keeps the grant indefinitely; its counter parks at CNT_MAX.
  assign w_hold    = r_grant_valid && request[r_grant_id] && (w_locked || (r_cnt < CNT_MAX));
  assign w_cnt_inc = (r_cnt < CNT_MAX) ? r_cnt + CW'(1) : r_cnt;

  // Scan starts just after the last winner and wraps to include it, so a lone requester is re-granted.
  always_comb begin
    int j;
    j        = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 1; i <= N; i++) begin
      j = int'(r_last) + i;
      if (j >= N) j = j - N;
      if (!w_found && request[j]) begin
        w_found  = 1'b1;
        w_winner = IDW'(j);
      end
    end
  end

  always_comb begin
    w_grant_nxt       = '0;
    w_grant_id_nxt    = r_grant_id;
    w_grant_valid_nxt = 1'b0;
    w_cnt_nxt         = '0;
    w_last_nxt        = r_last;
    if (w_hold) begin
      w_grant_nxt       = r_grant;
      w_grant_valid_nxt = 1'b1;
      w_cnt_nxt         = w_cnt_inc;
    end else if (w_found) begin
      w_grant_nxt       = {{(N-1){1'b0}}, 1'b1} << w_winner;
      w_grant_id_nxt    = w_winner;
      w_grant_valid_nxt = 1'b1;
      w_last_nxt        = w_winner;
    end
    w_burst_last_nxt = w_grant_valid_nxt && (w_cnt_nxt == CNT_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_burst_last  <= 1'b0;
      r_cnt         <= '0;
      r_last        <= IDW'(N - 1);
    end else begin
      r_grant       <= w_grant_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_burst_last  <= w_burst_last_nxt;
      r_cnt         <= w_cnt_nxt;
      r_last        <= w_last_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign grant_valid = r_grant_valid;
  assign burst_last  = r_burst_last;

endmodule
